// File: rtl/channel_error_injector_if.sv
// Symbol/config bundle for channel_error_injector.
//   cfg_*          : run-time injection configuration, latched on cfg_wr_i
//   sym_valid_i/_i : encoder symbol stream in
//   sym_valid_o/_o : registered (possibly corrupted) symbol stream out
//   err_flag_o     : current sym_o was corrupted
//   err_count_o    : saturating count of corrupted symbols
//   busy_o         : injector is in its RUN state
// Modports: slave = injector, master = driver/monitor.
interface channel_error_injector_if #(
  parameter int unsigned CNT_W = 11,
  parameter int unsigned ERR_W = 16
);
  logic             cfg_wr_i;
  logic [CNT_W-1:0] cfg_period_i;
  logic [2:0]       cfg_burst_i;
  logic [1:0]       cfg_mask_i;
  logic             cfg_oneshot_i;
  logic             sym_valid_i;
  logic [1:0]       sym_i;
  logic             sym_valid_o;
  logic [1:0]       sym_o;
  logic             err_flag_o;
  logic [ERR_W-1:0] err_count_o;
  logic             busy_o;

  modport slave (
    input  cfg_wr_i, cfg_period_i, cfg_burst_i, cfg_mask_i, cfg_oneshot_i,
    input  sym_valid_i, sym_i,
    output sym_valid_o, sym_o, err_flag_o, err_count_o, busy_o
  );

  modport master (
    output cfg_wr_i, cfg_period_i, cfg_burst_i, cfg_mask_i, cfg_oneshot_i,
    output sym_valid_i, sym_i,
    input  sym_valid_o, sym_o, err_flag_o, err_count_o, busy_o
  );
endinterface

// File: rtl/channel_error_injector.sv
// Error-injection scheduler between convolutional encoder and Viterbi decoder.
// Registers every 2-bit symbol and XORs the configured mask onto the last
// min(B, P) valid symbols of each P-symbol window. Modes: periodic, burst,
// one-shot (first window only).
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : channel_error_injector_if.slave (config, symbol in/out, status)
module channel_error_injector #(
  parameter int unsigned CNT_W = 11,
  parameter int unsigned ERR_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  channel_error_injector_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] k_q;
  logic [2:0]       burst_q;
  logic [1:0]       mask_q;
  logic             oneshot_q;
  logic [1:0]       sym_q;
  logic             sym_valid_q;
  logic             err_flag_q;
  logic             busy_q;
  logic [ERR_W-1:0] err_count_q;

  logic [CNT_W-1:0] burst_ext;
  logic [CNT_W-1:0] burst_eff;
  logic             last_sym;
  logic             corrupt;

  always_comb begin
    burst_ext = CNT_W'(burst_q);
    // Burst longer than the window corrupts the whole window.
    burst_eff = (burst_ext > period_q) ? period_q : burst_ext;
    last_sym  = (k_q == period_q - CNT_W'(1));
    corrupt   = (state_q == StRun) && bus.sym_valid_i &&
                (k_q >= period_q - burst_eff) && (mask_q != 2'b00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      period_q    <= '0;
      k_q         <= '0;
      burst_q     <= '0;
      mask_q      <= '0;
      oneshot_q   <= 1'b0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      err_flag_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      // Datapath always uses the state/config in force this cycle.
      sym_valid_q <= bus.sym_valid_i;
      sym_q       <= corrupt ? (bus.sym_i ^ mask_q) : bus.sym_i;
      err_flag_q  <= corrupt;

      if (bus.cfg_wr_i) begin
        // Reconfiguration clears the counter, overriding any same-cycle increment.
        period_q    <= bus.cfg_period_i;
        burst_q     <= bus.cfg_burst_i;
        mask_q      <= bus.cfg_mask_i;
        oneshot_q   <= bus.cfg_oneshot_i;
        k_q         <= '0;
        err_count_q <= '0;
        if (bus.cfg_period_i != '0) begin
          state_q <= StRun;
          busy_q  <= 1'b1;
        end else begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      end else begin
        if (corrupt && (err_count_q != '1)) begin
          err_count_q <= err_count_q + ERR_W'(1);
        end
        if ((state_q == StRun) && bus.sym_valid_i) begin
          if (last_sym) begin
            k_q <= '0;
            if (oneshot_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
            end
          end else begin
            k_q <= k_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.sym_valid_o = sym_valid_q;
  assign bus.sym_o       = sym_q;
  assign bus.err_flag_o  = err_flag_q;
  assign bus.err_count_o = err_count_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_channel_error_injector.sv
// Directed self-checking bench for channel_error_injector (ERR_W=4 so that
// counter saturation is reachable quickly).
module tb_channel_error_injector;
  localparam int unsigned CNT_W = 11;
  localparam int unsigned ERR_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  channel_error_injector_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  channel_error_injector #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [CNT_W-1:0] p, input logic [2:0] b, input logic [1:0] m,
                         input logic o);
    bus.cfg_period_i  = p;
    bus.cfg_burst_i   = b;
    bus.cfg_mask_i    = m;
    bus.cfg_oneshot_i = o;
  endtask

  // One clock: inputs applied at negedge, outputs sampled 1 after posedge.
  task automatic cycle(input logic wr, input logic v, input logic [1:0] s);
    @(negedge clk);
    bus.cfg_wr_i    = wr;
    bus.sym_valid_i = v;
    bus.sym_i       = s;
    @(posedge clk);
    #1;
    bus.cfg_wr_i = 1'b0;
  endtask

  task automatic check_sym(input string tag, input logic v, input logic [1:0] s, input logic f);
    check({tag, "_valid"}, bus.sym_valid_o, v);
    check({tag, "_sym"}, bus.sym_o, s);
    check({tag, "_flag"}, bus.err_flag_o, f);
  endtask

  task automatic check_zero(input string tag);
    check_sym(tag, 1'b0, 2'b00, 1'b0);
    check({tag, "_cnt"}, bus.err_count_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          exp_cnt;
    int          j;
    logic        fl;
    logic        v;
    logic [23:0] vpat;

    rst = 1'b0;
    bus.cfg_wr_i = 1'b0;
    bus.sym_valid_i = 1'b0;
    bus.sym_i = 2'b00;
    set_cfg('0, 3'd0, 2'b00, 1'b0);
    #22;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Periodic burst: P=32, B=3, mask=10 -> symbols 29..31 of each window.
    set_cfg(11'd32, 3'd3, 2'b10, 1'b0);
    cycle(1'b1, 1'b0, 2'b00);
    check("per_busy0", bus.busy_o, 1);
    check("per_cnt0", bus.err_count_o, 0);
    exp_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 1'b1, 2'b11);
      fl = ((i % 32) >= 29);
      if (fl) exp_cnt++;
      check_sym($sformatf("per%0d", i), 1'b1, fl ? 2'b01 : 2'b11, fl);
      check($sformatf("per%0d_cnt", i), bus.err_count_o, exp_cnt);
    end
    check("per_cnt", bus.err_count_o, 6);
    check("per_busy", bus.busy_o, 1);

    // One-shot: P=16, B=1, mask=11 -> only symbol 15, then DONE.
    set_cfg(11'd16, 3'd1, 2'b11, 1'b1);
    cycle(1'b1, 1'b0, 2'b00);
    check("os_cnt0", bus.err_count_o, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 2'b00);
      fl = (i == 15);
      check_sym($sformatf("os%0d", i), 1'b1, fl ? 2'b11 : 2'b00, fl);
      check($sformatf("os%0d_busy", i), bus.busy_o, (i < 15) ? 1 : 0);
    end
    check("os_cnt", bus.err_count_o, 1);

    // Burst clamp: B=7 > P=4 -> every valid symbol flipped on g0.
    set_cfg(11'd4, 3'd7, 2'b01, 1'b0);
    cycle(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] s;
      s = 2'(i);
      v = ((i % 2) == 0);
      cycle(1'b0, v, s);
      check_sym($sformatf("clamp%0d", i), v, v ? (s ^ 2'b01) : s, v);
    end
    check("clamp_cnt", bus.err_count_o, 8);

    // Valid gaps freeze k: P=4, B=1 -> every 4th valid symbol flipped.
    set_cfg(11'd4, 3'd1, 2'b01, 1'b0);
    cycle(1'b1, 1'b0, 2'b00);
    vpat = 24'b1011_0110_1110_0101_1101_0011;
    j = 0;
    exp_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      v  = vpat[i];
      fl = v && ((j % 4) == 3);
      if (v) j++;
      if (fl) exp_cnt++;
      cycle(1'b0, v, 2'b10);
      check_sym($sformatf("gap%0d", i), v, fl ? 2'b11 : 2'b10, fl);
    end
    check("gap_cnt", bus.err_count_o, exp_cnt);

    // Disable mid-run, then stray cfg inputs without cfg_wr_i are ignored.
    set_cfg(11'd0, 3'd3, 2'b11, 1'b0);
    cycle(1'b1, 1'b0, 2'b00);
    check("dis_busy", bus.busy_o, 0);
    check("dis_cnt", bus.err_count_o, 0);
    set_cfg(11'd2, 3'd2, 2'b11, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 2'(i));
      check_sym($sformatf("pass%0d", i), 1'b1, 2'(i), 1'b0);
      check($sformatf("pass%0d_busy", i), bus.busy_o, 0);
    end
    check("pass_cnt", bus.err_count_o, 0);

    // Reconfigure on the k=P-1 symbol: old config corrupts it, count cleared.
    set_cfg(11'd4, 3'd1, 2'b10, 1'b0);
    cycle(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 2'b00);
      check_sym($sformatf("rc%0d", i), 1'b1, 2'b00, 1'b0);
    end
    set_cfg(11'd8, 3'd2, 2'b01, 1'b0);
    cycle(1'b1, 1'b1, 2'b00);
    check_sym("rc_edge", 1'b1, 2'b10, 1'b1);
    check("rc_edge_cnt", bus.err_count_o, 0);
    check("rc_edge_busy", bus.busy_o, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 2'b00);
      fl = (i >= 6);
      check_sym($sformatf("rn%0d", i), 1'b1, fl ? 2'b01 : 2'b00, fl);
    end
    check("rn_cnt", bus.err_count_o, 2);

    // Saturation: P=1, B=1 -> every symbol flipped, count stops at 15.
    set_cfg(11'd1, 3'd1, 2'b10, 1'b0);
    cycle(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 2'b00);
      check_sym($sformatf("sat%0d", i), 1'b1, 2'b10, 1'b1);
      check($sformatf("sat%0d_cnt", i), bus.err_count_o, (i < 15) ? i + 1 : 15);
    end

    // Reset during symbol 30 of a P=32/B=3 run.
    set_cfg(11'd32, 3'd3, 2'b10, 1'b0);
    cycle(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 2'b11);
    check("pre_rst_flag", bus.err_flag_o, 1);
    @(negedge clk);
    bus.sym_valid_i = 1'b1;
    bus.sym_i = 2'b11;
    #2;
    rst = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 2'(i));
      check_sym($sformatf("post%0d", i), 1'b1, 2'(i), 1'b0);
    end
    check("post_busy", bus.busy_o, 0);
    check("post_cnt", bus.err_count_o, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/channel_error_injector.md
# channel_error_injector

Programmable error-injection scheduler between the convolutional encoder output and the Viterbi decoder input in the tx/rx loopback. It registers each 2-bit encoder symbol and flips selected bits on a configured burst of symbols at the end of every injection window. Supported modes are periodic, adjacent-burst and one-shot. It replaces hand-edited injection counters with run-time configuration, so one build covers all BER test modes.

## Interface

- CNT_W, 11 — window counter / period width; max period 2^CNT_W−1 symbols
- ERR_W, 16 — width of the injected-symbol counter

- clk  in  1  — clock
- rst  in  1  — asynchronous, active-low reset
- cfg_wr_i  in  1  — load configuration this cycle
- cfg_period_i  in  CNT_W  — window length P in valid symbols; 0 = injection off
- cfg_burst_i  in  3  — burst length B, corrupted symbols per window (0–7)
- cfg_mask_i  in  2  — XOR mask applied to corrupted symbols
- cfg_oneshot_i  in  1  — inject in the first window only
- sym_valid_i  in  1  — encoder symbol valid
- sym_i  in  2  — encoder symbol {g1,g0}
- sym_valid_o  out  1  — registered sym_valid_i; drives decoder enable
- sym_o  out  2  — registered, possibly corrupted symbol
- err_flag_o  out  1  — the sym_o on this cycle was corrupted
- err_count_o  out  ERR_W  — total corrupted symbols, saturating
- busy_o  out  1  — high in state RUN

## Operation

- States: IDLE (pass-through), RUN (injecting), DONE (one-shot finished, pass-through).
- Config registers (P, B, mask, oneshot) reset to 0.
- Effective burst Be = min(B, P).
- Window index k counts 0..P−1 and advances only on cycles with sym_valid_i=1.
  - When k=P−1 and the symbol is valid, k wraps to 0.
  - If oneshot is set, that wrap also moves the state RUN→DONE.
- A symbol is corrupted iff state=RUN, sym_valid_i=1, k ≥ P−Be and mask≠0.
  - Corrupted: sym_o ← sym_i XOR mask and err_flag_o ← 1.
  - Otherwise: sym_o ← sym_i and err_flag_o ← 0.
- Example: P=32, B=3, mask=2'b10 flips g1 on symbols 29, 30 and 31 of every 32.
- sym_i is registered every cycle, even when invalid. err_flag_o is 0 on any cycle with an invalid symbol.
- cfg_wr_i, any state:
  - Latches all cfg inputs and sets k←0.
  - Goes to RUN if cfg_period_i≠0, else IDLE.
  - Clears err_count_o to 0.
- err_count_o increments on each corrupted symbol and saturates at 2^ERR_W−1.
- cfg_wr_i in the same cycle as a valid symbol:
  - That symbol is processed with the old state/config, and its err_count increment is dropped, because the clear wins.
  - The new config applies from the next valid symbol at k=0.
- Reset, at any time including mid-burst:
  - sym_o=0, sym_valid_o=0, err_flag_o=0, err_count_o=0, busy_o=0.
  - State IDLE, k=0, config registers cleared.

## Timing

- Latency is exactly 1 cycle: sym_valid_o, sym_o and err_flag_o in cycle n+1 reflect sym_valid_i/sym_i in cycle n.
- No backpressure; one symbol per cycle is accepted.
- busy_o and err_count_o are registered. They update in the cycle after the triggering event.
- RUN→DONE: busy_o falls in the cycle after the last symbol of the first window is accepted.
- Gaps in sym_valid_i freeze k. Burst positions are defined in valid symbols, not clock cycles.
- Config changes take effect only through cfg_wr_i. Cfg inputs are ignored on other cycles.

## Test plan

- **Periodic adjacent burst.** Write P=32, B=3, mask=2'b10, oneshot=0, then 64 consecutive valid symbols of 2'b11 → symbols 29–31 and 61–63 come out 2'b01 with err_flag_o=1; all others 2'b11; err_count_o=6; busy_o stays 1.
- **One-shot.**
  - Write P=16, B=1, mask=2'b11, oneshot=1, then 40 valid 2'b00 symbols.
  - Only symbol 15 is corrupted, output 2'b11.
  - busy_o falls 1 cycle after symbol 15; state is DONE; err_count_o=1.
- **Burst clamp and valid gaps.**
  - P=4, B=7, mask=2'b01, valid toggling every other cycle → every valid symbol flipped on g0.
  - Invalid cycles give err_flag_o=0, and k does not advance.
- **Disable and reconfigure.**
  - Mid-run, cfg_wr_i with P=0 → IDLE, busy_o=0, pure pass-through, err_count_o=0.
  - cfg_wr_i coincident with a valid symbol at k=P−1: that symbol uses the old config; the next valid symbol is k=0 of the new window.
- **Saturation.** ERR_W=4, P=1, B=1, mask=2'b10, 20 valid symbols → err_count_o stops at 15; all 20 symbols are still flipped.
- **Reset mid-burst.** Assert rst low during symbol 30 of the P=32/B=3 run → all outputs are 0 immediately; after release the block is in IDLE and symbols pass unmodified until the next cfg_wr_i.
